// File: rtl/matrix_scan_bcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_bcm_pkg
//  Purpose  : Shared types and helpers for the HUB75 BCM scan engine:
//             FSM state encoding, minimum-one-bit width helper and the
//             pixel-clock phase constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package matrix_scan_bcm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_BLANK = 3'd2,
      ST_LATCH = 3'd3,
      ST_SHOW  = 3'd4
   } state_t;

   // Each column occupies two cycles: low phase then high phase.
   localparam logic PH_LOW  = 1'b0;
   localparam logic PH_HIGH = 1'b1;

   // Counter width for n states, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_bcm_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_bcm_if
//  Purpose  : Panel-side bundle of the scan engine. The slave modport is the
//             scan engine, the master modport is its controller/consumer.
//  Signals  : enable (ctrl->engine), column_address, row_address,
//             brightness_mask, clk_pixel, row_latch, output_enable,
//             frame_start (engine->ctrl); dim_level (ctrl->engine) only when
//             MATRIX_DIM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface matrix_scan_bcm_if #(
   parameter int COLS       = 64,
   parameter int ROWS_SCAN  = 16,
   parameter int COLOR_BITS = 6
);
   localparam int COL_BITS = matrix_scan_bcm_pkg::width_of(COLS);
   localparam int ROW_BITS = matrix_scan_bcm_pkg::width_of(ROWS_SCAN);

   logic                  enable;
   logic [COL_BITS-1:0]   column_address;
   logic [ROW_BITS-1:0]   row_address;
   logic [COLOR_BITS-1:0] brightness_mask;
   logic                  clk_pixel;
   logic                  row_latch;
   logic                  output_enable;
   logic                  frame_start;
`ifdef MATRIX_DIM_EN
   logic [7:0]            dim_level;
`endif

   modport slave (
      input  enable,
`ifdef MATRIX_DIM_EN
      input  dim_level,
`endif
      output column_address, row_address, brightness_mask,
      output clk_pixel, row_latch, output_enable, frame_start
   );

   modport master (
      output enable,
`ifdef MATRIX_DIM_EN
      output dim_level,
`endif
      input  column_address, row_address, brightness_mask,
      input  clk_pixel, row_latch, output_enable, frame_start
   );

endinterface
`default_nettype wire

// File: rtl/matrix_scan_bcm_show_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcm_show_timer
//  Purpose  : Loadable down-counter timing one SHOW interval, plus a second
//             counter giving the (optionally dimmed) OE-on window at its start.
//  Ports    : clk_in, reset (async active-low), i_load (load in LATCH),
//             i_run (count in SHOW), i_len (SHOW length), i_dim (dim level,
//             8'hFF = full on), o_done (last SHOW cycle), o_oe_win (OE allowed)
//  Revision : 1.0  initial release
// ============================================================================
module bcm_show_timer #(
   parameter int SHOW_W = 3
) (
   input  wire logic              clk_in,
   input  wire logic              reset,
   input  wire logic              i_load,
   input  wire logic              i_run,
   input  wire logic [SHOW_W-1:0] i_len,
   input  wire logic [7:0]        i_dim,
   output logic                   o_done,
   output logic                   o_oe_win
);
   logic [SHOW_W-1:0]   r_cnt;
   logic [SHOW_W-1:0]   r_win;
   logic [SHOW_W+7:0]   w_prod;
   logic [SHOW_W-1:0]   w_win_len;

   // On-window = (len * (dim+1)) >> 8; dim=255 yields the full length.
   assign w_prod    = (SHOW_W+8)'(i_len) * (SHOW_W+8)'({1'b0, i_dim} + 9'd1);
   assign w_win_len = SHOW_W'(w_prod >> 8);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_win <= '0;
      end else if (i_load) begin
         r_cnt <= i_len;
         r_win <= w_win_len;
      end else if (i_run) begin
         if (r_cnt > SHOW_W'(1)) r_cnt <= r_cnt - SHOW_W'(1);
         if (r_win != '0)        r_win <= r_win - SHOW_W'(1);
      end
   end

   assign o_done   = (r_cnt == SHOW_W'(1));
   assign o_oe_win = (r_win != '0);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_bcm
//  Purpose  : HUB75 scan engine walking row x bit-plane x column with
//             binary-coded-modulation on-times (plane b lit LSB_ON_CYCLES<<b).
//  Ports    : clk_in, reset (async active-low), bus (matrix_scan_bcm_if.slave:
//             enable in; column/row address, brightness_mask, clk_pixel,
//             row_latch, output_enable, frame_start out).
//  Config   : MATRIX_DIM_EN adds bus.dim_level global dimming of the OE window.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_scan_bcm
   import matrix_scan_bcm_pkg::*;
#(
   parameter int COLS          = 64,
   parameter int ROWS_SCAN     = 16,
   parameter int COLOR_BITS    = 6,
   parameter int BLANK_CYCLES  = 2,
   parameter int LSB_ON_CYCLES = 1
) (
   input  wire logic         clk_in,
   input  wire logic         reset,
   matrix_scan_bcm_if.slave  bus
);
   localparam int COL_BITS   = width_of(COLS);
   localparam int ROW_BITS   = width_of(ROWS_SCAN);
   localparam int PLANE_BITS = width_of(COLOR_BITS);
   localparam int BLK_W      = width_of(BLANK_CYCLES);
   localparam int SHOW_W     = $clog2((LSB_ON_CYCLES << (COLOR_BITS-1)) + 1);

   state_t                r_state, w_next;
   logic [COL_BITS-1:0]   r_col;
   logic                  r_phase;
   logic [BLK_W-1:0]      r_blank;
   logic [ROW_BITS-1:0]   r_row;
   logic [PLANE_BITS-1:0] r_plane;

   logic                  w_shift_last, w_blank_last, w_show_done, w_oe_win;
   logic [SHOW_W-1:0]     w_show_len;
   logic [7:0]            w_dim;
   logic [COL_BITS-1:0]   w_col;
   logic [ROW_BITS-1:0]   w_row;
   logic [COLOR_BITS-1:0] w_mask;
   logic                  w_clk_pixel, w_latch, w_oe, w_frame_start;

`ifdef MATRIX_DIM_EN
   assign w_dim = bus.dim_level;
`else
   assign w_dim = 8'hFF;
`endif

   assign w_shift_last = (r_phase == PH_HIGH) && (r_col == COL_BITS'(COLS-1));
   assign w_blank_last = (r_blank == BLK_W'(BLANK_CYCLES-1));
   assign w_show_len   = SHOW_W'(LSB_ON_CYCLES << r_plane);

   bcm_show_timer #(.SHOW_W(SHOW_W)) u_timer (
      .clk_in   (clk_in),
      .reset    (reset),
      .i_load   (r_state == ST_LATCH),
      .i_run    (r_state == ST_SHOW),
      .i_len    (w_show_len),
      .i_dim    (w_dim),
      .o_done   (w_show_done),
      .o_oe_win (w_oe_win)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next state and decoded outputs. Outputs derive from reset registers so
   // OE and latch drop the instant reset asserts.
   always_comb begin
      w_next        = r_state;
      w_col         = '0;
      w_row         = '0;
      w_mask        = '0;
      w_clk_pixel   = 1'b0;
      w_latch       = 1'b0;
      w_oe          = 1'b0;
      w_frame_start = 1'b0;
      if (r_state != ST_IDLE) begin
         w_col  = r_col;
         w_row  = r_row;
         w_mask = COLOR_BITS'(1) << r_plane;
      end
      case (r_state)
         ST_IDLE:  if (bus.enable) w_next = ST_SHIFT;
         ST_SHIFT: begin
            w_clk_pixel   = r_phase;
            w_frame_start = (r_row == '0) && (r_plane == '0) &&
                            (r_col == '0) && (r_phase == PH_LOW);
            if (w_shift_last) w_next = ST_BLANK;
         end
         ST_BLANK: if (w_blank_last) w_next = ST_LATCH;
         ST_LATCH: begin
            w_latch = 1'b1;
            w_next  = ST_SHOW;
         end
         ST_SHOW: begin
            w_oe = w_oe_win;
            // enable only matters here, so a plane is never cut short.
            if (w_show_done) w_next = bus.enable ? ST_SHIFT : ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_col   <= '0;
         r_phase <= PH_LOW;
         r_blank <= '0;
         r_row   <= '0;
         r_plane <= '0;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               r_phase <= ~r_phase;
               if (r_phase == PH_HIGH)
                  r_col <= w_shift_last ? '0 : r_col + COL_BITS'(1);
            end
            ST_BLANK: r_blank <= w_blank_last ? '0 : r_blank + BLK_W'(1);
            ST_SHOW: begin
               if (w_show_done) begin
                  if (r_plane == PLANE_BITS'(COLOR_BITS-1)) begin
                     r_plane <= '0;
                     r_row   <= (r_row == ROW_BITS'(ROWS_SCAN-1)) ? '0
                                                                   : r_row + ROW_BITS'(1);
                  end else begin
                     r_plane <= r_plane + PLANE_BITS'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.column_address  = w_col;
   assign bus.row_address     = w_row;
   assign bus.brightness_mask = w_mask;
   assign bus.clk_pixel       = w_clk_pixel;
   assign bus.row_latch       = w_latch;
   assign bus.output_enable   = w_oe;
   assign bus.frame_start     = w_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_bcm
//  Purpose  : Self-checking bench for matrix_scan_bcm with COLS=4,
//             ROWS_SCAN=2, COLOR_BITS=3, BLANK_CYCLES=2, LSB_ON_CYCLES=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_scan_bcm;

   typedef struct packed {
      logic [1:0] col;
      logic       row;
      logic [2:0] mask;
      logic       clkp;
      logic       latch;
      logic       oe;
      logic       fs;
   } vec_t;

   typedef struct packed {
      logic en;
      vec_t exp;
   } rec_t;

   logic clk_in = 1'b0;
   logic reset  = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk_in = ~clk_in;

   matrix_scan_bcm_if #(.COLS(4), .ROWS_SCAN(2), .COLOR_BITS(3)) bus ();

   matrix_scan_bcm #(
      .COLS(4), .ROWS_SCAN(2), .COLOR_BITS(3),
      .BLANK_CYCLES(2), .LSB_ON_CYCLES(1)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t cur();
      return {bus.column_address, bus.row_address, bus.brightness_mask,
              bus.clk_pixel, bus.row_latch, bus.output_enable, bus.frame_start};
   endfunction

   function automatic vec_t mk(input int c, input logic r, input logic [2:0] m,
                               input logic cp, input logic lt, input logic oe,
                               input logic fs);
      vec_t v;
      v.col = 2'(c); v.row = r; v.mask = m;
      v.clkp = cp; v.latch = lt; v.oe = oe; v.fs = fs;
      return v;
   endfunction

   task automatic measure_plane(input logic [2:0] m, output int len, output int oec);
      len = 0;
      oec = 0;
      while (bus.brightness_mask == m && len < 200) begin
         len++;
         if (bus.output_enable) oec++;
         step();
      end
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.frame_start && n < 300);
   endtask

   rec_t tbl[13];
   int   len, oec, n;
   logic ok;

   initial begin
      // First plane after enable: 4 columns x 2 phases, 2 blank, latch, 1 show.
      for (int c = 0; c < 4; c++) begin
         tbl[2*c]   = {1'b1, mk(c, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, c == 0)};
         tbl[2*c+1] = {1'b1, mk(c, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0)};
      end
      tbl[8]  = {1'b1, mk(0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[9]  = {1'b1, mk(0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[10] = {1'b1, mk(0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0)};
      tbl[11] = {1'b1, mk(0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0)};
      tbl[12] = {1'b1, mk(0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0)};

      bus.enable = 1'b0;
`ifdef MATRIX_DIM_EN
      bus.dim_level = 8'hFF;
`endif
      reset = 1'b0;
      repeat (3) step();
      chk("reset_outputs", 32'(cur()), 32'(vec_t'(0)));
      reset = 1'b1;
      step();
      chk("idle_after_release", 32'(cur()), 32'(vec_t'(0)));

      for (int i = 0; i < 13; i++) begin
         bus.enable = tbl[i].en;
         step();
         chk($sformatf("plane0_cycle%0d", i), 32'(cur()), 32'(tbl[i].exp));
      end

      measure_plane(3'b010, len, oec);
      chk("plane1_len", len, 13);
      chk("plane1_oe", oec, 2);
      measure_plane(3'b100, len, oec);
      chk("plane2_len", len, 15);
      chk("plane2_oe", oec, 4);
      chk("row1_plane0_start", 32'(cur()), 32'(mk(0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0)));

      // Frame start cadence: row 1 is half a frame, then a full frame.
      wait_fs(n);
      chk("fs_after_row1", n, 40);
      chk("fs_row0", 32'(bus.row_address), 0);
      step();
      chk("fs_width", 32'(bus.frame_start), 0);
      wait_fs(n);
      chk("fs_period", n + 1, 80);

      // Drop enable mid-SHIFT of row 1 plane 1.
      n = 0;
      while (!(bus.row_address == 1'b1 && bus.brightness_mask == 3'b010) && n < 300) begin
         step();
         n++;
      end
      chk("reach_row1_plane1", 32'(n < 300), 1);
      repeat (3) step();
      bus.enable = 1'b0;
      n = 0;
      oec = 0;
      while (bus.brightness_mask != 3'b000 && n < 100) begin
         if (bus.output_enable) oec++;
         step();
         n++;
      end
      chk("disable_remaining_cycles", n, 10);
      chk("disable_show_oe", oec, 2);
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (cur() != vec_t'(0)) ok = 1'b0;
         step();
      end
      chk("idle_outputs_zero", 32'(ok), 1);
      bus.enable = 1'b1;
      step();
      chk("resume_row1_plane2", 32'(cur()), 32'(mk(0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0)));

      // Asynchronous reset during SHOW.
      n = 0;
      while (!bus.output_enable && n < 100) begin
         step();
         n++;
      end
      chk("reach_show", 32'(bus.output_enable), 1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outputs", 32'(cur()), 32'(vec_t'(0)));
      @(negedge clk_in);
      reset = 1'b1;
      step();
      chk("restart_frame_start", 32'(cur()), 32'(mk(0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1)));

`ifdef MATRIX_DIM_EN
      // Half dimming: windows (1,2,4)*128>>8 = 0,1,2; then fully dark.
      reset = 1'b0;
      bus.dim_level = 8'd127;
      step();
      reset = 1'b1;
      step();
      chk("dim_fs", 32'(bus.frame_start), 1);
      measure_plane(3'b001, len, oec);
      chk("dim127_p0_oe", oec, 0);
      measure_plane(3'b010, len, oec);
      chk("dim127_p1_oe", oec, 1);
      measure_plane(3'b100, len, oec);
      chk("dim127_p2_len", len, 15);
      chk("dim127_p2_oe", oec, 2);
      bus.dim_level = 8'd0;
      n = 0;
      for (int p = 0; p < 3; p++) begin
         measure_plane(3'(1 << p), len, oec);
         n += oec;
      end
      chk("dim0_oe_total", n, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
